// File: rtl/joy_link_pkg.sv
// Shared definitions for the serial joystick link: frame size, FSM states and
// the bit ordering used by both the responder and the reader's decode.
package joy_link_pkg;

  localparam int FRAME_BITS  = 24;
  localparam int JOY_W       = 12;
  localparam int JOY_FRAME_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } joy_state_e;

  // Bit i of the result is the level presented at frame position i.
  function automatic logic [JOY_FRAME_W-1:0] joy_frame(
    input logic [JOY_W-1:0] j1,
    input logic [JOY_W-1:0] j2
  );
    logic [7:0] lane1;
    logic [7:0] lane2;
    lane1 = {j1[0], j1[1], j1[2], j1[3], j1[4], j1[5], j1[6], j1[8]};
    lane2 = {j2[0], j2[1], j2[2], j2[3], j2[4], j2[5], j2[6], j2[8]};
    return {j1[7], j1[9], j1[11], j1[10],
            j2[7], j2[9], j2[11], j2[10],
            lane2, lane1};
  endfunction

endpackage

// File: rtl/joy_serializer_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with single-cycle
// rise/fall strobes derived from the last stage and its delayed copy.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk12,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_sync;
  logic         r_old;

  // Synchronizer chain plus one extra flop holding the previous synced level.
  always_ff @(posedge clk12) begin
    if (!reset_n) begin
      r_sync <= {N{RESET_VAL}};
      r_old  <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[N-2:0], i_async};
      r_old  <= r_sync[N-1];
    end
  end

  assign o_level = r_sync[N-1];
  assign o_rise  = r_sync[N-1] & ~r_old;
  assign o_fall  = ~r_sync[N-1] & r_old;

endmodule

// File: rtl/joy_serializer.sv
// Responder end of the serial joystick link: emulates a 74HC165-style chain,
// loading two active-low joystick words and shifting them out on JOY_CLK.
module joy_serializer
  import joy_link_pkg::*;
#(
  parameter int FRAME_BITS  = joy_link_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk12,
  input  logic        reset_n,
  input  logic        joy_clk_in,
  input  logic        joy_load_in,
  input  logic [11:0] joystick1_n,
  input  logic [11:0] joystick2_n,
  output logic        joy_data_out,
  output logic        frame_done,
  output logic [4:0]  bit_count,
  output logic        overrun
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);

  logic                               w_clk_level;
  logic                               w_clk_rise;
  logic                               w_clk_fall;
  logic                               w_load_level;
  logic                               w_load_rise;
  logic                               w_load_fall;
  logic                               w_load_act;
  logic [JOY_FRAME_W-1:0]             w_frame;
  logic [FRAME_BITS+JOY_FRAME_W-1:0]  w_frame_pad;
  logic [FRAME_BITS-1:0]              w_load_word;
  logic                               w_unused;

  joy_state_e            r_state;
  logic [FRAME_BITS-1:0] r_shreg;
  logic                  r_data;
  logic                  r_frame_done;
  logic [4:0]            r_bit_count;
  logic                  r_overrun;

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_clk_sync (
    .clk12   (clk12),
    .reset_n (reset_n),
    .i_async (joy_clk_in),
    .o_level (w_clk_level),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_load_sync (
    .clk12   (clk12),
    .reset_n (reset_n),
    .i_async (joy_load_in),
    .o_level (w_load_level),
    .o_rise  (w_load_rise),
    .o_fall  (w_load_fall)
  );

  assign w_load_act  = ~w_load_level;
  assign w_frame     = joy_frame(joystick1_n, joystick2_n);
  // Frames longer than the joystick payload are padded with idle-high bits.
  assign w_frame_pad = {{FRAME_BITS{1'b1}}, w_frame};
  assign w_load_word = w_frame_pad[FRAME_BITS-1:0];
  assign w_unused    = &{1'b0, w_clk_level, w_clk_fall, w_load_rise, w_load_fall,
                         w_frame_pad[FRAME_BITS+JOY_FRAME_W-1:FRAME_BITS]};

  // Link FSM: r_data is the presented bit, r_shreg holds the bits still to come.
  always_ff @(posedge clk12) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= {FRAME_BITS{1'b1}};
      r_data       <= 1'b1;
      r_frame_done <= 1'b0;
      r_bit_count  <= 5'd0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_load_act) begin
        // Load has priority over a coincident shift clock.
        r_state     <= ST_LOAD;
        r_shreg     <= {1'b1, w_load_word[FRAME_BITS-1:1]};
        r_data      <= w_load_word[0];
        r_bit_count <= 5'd0;
        r_overrun   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_data <= 1'b1;
          end
          ST_LOAD: begin
            r_state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_clk_rise) begin
              r_bit_count <= r_bit_count + 5'd1;
              r_shreg     <= {1'b1, r_shreg[FRAME_BITS-1:1]};
              if (r_bit_count == LAST_IDX) begin
                r_state      <= ST_DONE;
                r_data       <= 1'b1;
                r_frame_done <= 1'b1;
              end else begin
                r_data <= r_shreg[0];
              end
            end
          end
          ST_DONE: begin
            r_data <= 1'b1;
            if (w_clk_rise) begin
              r_overrun <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_data  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign joy_data_out = r_data;
  assign frame_done   = r_frame_done;
  assign bit_count    = r_bit_count;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_joy_serializer.sv
// Scoreboard bench for joy_serializer: expected serial bits are queued when a
// frame is issued and popped by a monitor on every reader sampling edge.
`timescale 1ns/1ps
module tb_joy_serializer;

  logic        clk12 = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_clk_in = 1'b0;
  logic        joy_load_in = 1'b1;
  logic [11:0] joystick1_n = 12'hFFF;
  logic [11:0] joystick2_n = 12'hFFF;
  logic        joy_data_out;
  logic        frame_done;
  logic [4:0]  bit_count;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int half = 27;
  bit mon_en = 1'b1;
  bit prev_done = 1'b0;
  bit q_exp[$];
  int q_idx[$];

  localparam int LANE [8]  = '{8, 6, 5, 4, 3, 2, 1, 0};
  localparam int EXTRA [4] = '{10, 11, 9, 7};

  joy_serializer dut (
    .clk12        (clk12),
    .reset_n      (reset_n),
    .joy_clk_in   (joy_clk_in),
    .joy_load_in  (joy_load_in),
    .joystick1_n  (joystick1_n),
    .joystick2_n  (joystick2_n),
    .joy_data_out (joy_data_out),
    .frame_done   (frame_done),
    .bit_count    (bit_count),
    .overrun      (overrun)
  );

  always #41.667 clk12 = ~clk12;

  // Frame position -> pin level, built from the documented chain order.
  function automatic bit [23:0] model_frame(input bit [11:0] j1, input bit [11:0] j2);
    bit [23:0] f;
    for (int i = 0; i < 8; i++) begin
      f[i]     = j1[LANE[i]];
      f[8 + i] = j2[LANE[i]];
    end
    for (int i = 0; i < 4; i++) begin
      f[16 + i] = j2[EXTRA[i]];
      f[20 + i] = j1[EXTRA[i]];
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk12);
  endtask

  task automatic expect_frame(input bit [11:0] j1, input bit [11:0] j2, input int n);
    bit [23:0] f;
    f = model_frame(j1, j2);
    for (int k = 0; k < n; k++) begin
      q_exp.push_back((k < 24) ? f[k] : 1'b1);
      q_idx.push_back(k);
    end
  endtask

  task automatic load_pulse();
    joy_load_in = 1'b0;
    tick(24);
    joy_load_in = 1'b1;
    tick(half);
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      joy_clk_in = 1'b1;
      tick(half);
      joy_clk_in = 1'b0;
      tick(half);
    end
  endtask

  task automatic check_status(input int exp_cnt, input bit exp_ovr);
    check("bit_count", 32'(bit_count), 32'(exp_cnt));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("frame_done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic run_frame(input bit [11:0] j1, input bit [11:0] j2, input int n);
    joystick1_n = j1;
    joystick2_n = j2;
    expect_frame(j1, j2, n);
    load_pulse();
    clocks(n);
    if (n >= 24) exp_done++;
    check_status((n >= 24) ? 24 : n, n > 24);
  endtask

  // Reader-side monitor: the reader captures data on each rising JOY_CLK.
  always @(posedge joy_clk_in) begin
    if (mon_en) begin
      if (q_exp.size() == 0) begin
        check("unexpected_sample", 32'(q_exp.size()), 32'd1);
      end else begin
        bit e;
        int k;
        e = q_exp.pop_front();
        k = q_idx.pop_front();
        check($sformatf("data[%0d]", k), 32'(joy_data_out), 32'(e));
      end
    end
  end

  // frame_done pulse counter and width check.
  always @(negedge clk12) begin
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      check("frame_done_width", 32'(prev_done), 32'd0);
    end
    prev_done <= frame_done;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [11:0] j1;
    bit [11:0] j2;
    bit [23:0] f;
    int n;

    @(negedge clk12);
    reset_n = 1'b0;
    tick(3);
    check("rst_data", 32'(joy_data_out), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check_status(0, 1'b0);
    reset_n = 1'b1;
    tick(100);
    check("idle_data", 32'(joy_data_out), 32'd1);
    check_status(0, 1'b0);

    run_frame(12'hFFE, 12'hFFF, 24);

    // Inputs changed mid-shift must not disturb the frame in flight.
    joystick1_n = 12'hFFF;
    joystick2_n = 12'h7FF;
    expect_frame(12'hFFF, 12'h7FF, 24);
    load_pulse();
    clocks(5);
    joystick1_n = 12'h000;
    clocks(19);
    exp_done++;
    check_status(24, 1'b0);

    run_frame(12'($urandom), 12'($urandom), 25);
    load_pulse();
    check("overrun_cleared", 32'(overrun), 32'd0);

    for (int r = 0; r < 6; r++) begin
      half = $urandom_range(4, 20);
      n = $urandom_range(20, 26);
      run_frame(12'($urandom), 12'($urandom), n);
    end
    half = 27;

    // Load asserted together with shift clock edges at bit_count 10.
    j1 = 12'($urandom);
    j2 = 12'($urandom);
    joystick1_n = j1;
    joystick2_n = j2;
    expect_frame(j1, j2, 10);
    load_pulse();
    clocks(10);
    check("bit_count_pre_load", 32'(bit_count), 32'd10);
    mon_en = 1'b0;
    j1 = 12'($urandom) & 12'hEFF;
    j2 = 12'($urandom);
    joystick1_n = j1;
    joystick2_n = j2;
    joy_load_in = 1'b0;
    joy_clk_in = 1'b1;
    tick(half);
    joy_clk_in = 1'b0;
    tick(half);
    joy_clk_in = 1'b1;
    tick(half);
    joy_clk_in = 1'b0;
    tick(half);
    f = model_frame(j1, j2);
    check("load_hold_data", 32'(joy_data_out), 32'(f[0]));
    check_status(0, 1'b0);
    joy_load_in = 1'b1;
    tick(half);
    mon_en = 1'b1;
    expect_frame(j1, j2, 24);
    clocks(24);
    exp_done++;
    check_status(24, 1'b0);

    // Reset pulse in the middle of a frame.
    j1 = 12'($urandom);
    j2 = 12'($urandom);
    joystick1_n = j1;
    joystick2_n = j2;
    expect_frame(j1, j2, 12);
    load_pulse();
    clocks(12);
    check("bit_count_pre_reset", 32'(bit_count), 32'd12);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("post_reset_data", 32'(joy_data_out), 32'd1);
    check("post_reset_frame_done", 32'(frame_done), 32'd0);
    check_status(0, 1'b0);
    for (int k = 12; k < 24; k++) begin
      q_exp.push_back(1'b1);
      q_idx.push_back(k);
    end
    clocks(12);
    check_status(0, 1'b0);
    run_frame(12'($urandom), 12'($urandom), 24);

    check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
